// File: rtl/imm_compress.sv
// imm_compress: recovers the 16-bit immediate that the immediate extender would expand
// back to a given 32-bit value under a given extension op, flags exact representability,
// and buffers results in a 2-entry FIFO behind valid/ready handshakes on both sides.
// A saturating counter tracks how many accepted values were not representable.
module imm_compress #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_val,
  input  logic [1:0]       in_eop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_imm,
  output logic [1:0]       out_eop,
  output logic             out_fit,
  output logic [CNT_W-1:0] miss_cnt,
  input  logic             clr_cnt
);

  typedef struct packed {
    logic [15:0] imm;
    logic [1:0]  eop;
    logic        fit;
  } entry_t;

  entry_t             mem_q [2];
  entry_t             hold_q;
  entry_t             head;
  entry_t             comp;
  logic               wr_ptr_q;
  logic               rd_ptr_q;
  logic [1:0]         occ_q;
  logic [1:0]         occ_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic               push;
  logic               pop;
  logic               hi_sext16;
  logic               hi_sext18;

  // Compress the incoming value: pick the immediate field and check the discarded bits.
  always_comb begin
    comp      = '0;
    comp.eop  = in_eop;
    // Upper bits must be a pure sign extension of the kept field.
    hi_sext16 = (&in_val[31:15]) | ~(|in_val[31:15]);
    hi_sext18 = (&in_val[31:17]) | ~(|in_val[31:17]);
    case (in_eop)
      2'b00: begin
        comp.imm = in_val[15:0];
        comp.fit = hi_sext16;
      end
      2'b01: begin
        comp.imm = in_val[15:0];
        comp.fit = ~(|in_val[31:16]);
      end
      2'b10: begin
        comp.imm = in_val[31:16];
        comp.fit = ~(|in_val[15:0]);
      end
      default: begin
        comp.imm = in_val[17:2];
        comp.fit = ~(|in_val[1:0]) & hi_sext18;
      end
    endcase
  end

  // Handshake decode; in_ready depends on registered occupancy only.
  always_comb begin
    in_ready  = (occ_q < 2'd2);
    out_valid = (occ_q != 2'd0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready;
  end

  // Next occupancy: simultaneous push and pop leaves it unchanged.
  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Occupancy and read/write pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Buffer storage written at the write pointer on accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= comp;
    end
  end

  // Last popped entry, shown on the outputs while the buffer is empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_q <= '0;
    end else if (pop) begin
      hold_q <= head;
    end
  end

  // Output mux: head of FIFO when occupied, otherwise the last value seen.
  always_comb begin
    head    = mem_q[rd_ptr_q];
    out_imm = out_valid ? head.imm : hold_q.imm;
    out_eop = out_valid ? head.eop : hold_q.eop;
    out_fit = out_valid ? head.fit : hold_q.fit;
  end

  // Miss counter next state: clear wins over a coincident miss.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (push && !comp.fit && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Miss counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign miss_cnt = cnt_q;

endmodule

// File: tb/tb_imm_compress.sv
// Self-checking bench for imm_compress: directed scenarios plus randomized traffic,
// compared every cycle against an arithmetic reference model with a queue.
module tb_imm_compress;

  localparam int unsigned CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_val;
  logic [1:0]    in_eop;
  logic          out_valid;
  logic          out_ready;
  logic [15:0]   out_imm;
  logic [1:0]    out_eop;
  logic          out_fit;
  logic [CW-1:0] miss_cnt;
  logic          clr_cnt;

  always #5 clk = ~clk;

  imm_compress #(.CNT_W(CW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_val    (in_val),
    .in_eop    (in_eop),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_imm   (out_imm),
    .out_eop   (out_eop),
    .out_fit   (out_fit),
    .miss_cnt  (miss_cnt),
    .clr_cnt   (clr_cnt)
  );

  typedef struct {
    logic [15:0] imm;
    logic [1:0]  eop;
    logic        fit;
  } ent_t;

  ent_t q[$];
  ent_t last;
  int   mcnt;
  int   errors = 0;
  int   checks = 0;
  int   dpops  = 0;

  // Reference: field selection by shifting, fit by numeric range of the signed value.
  function automatic ent_t ref_compress(input logic [31:0] v, input logic [1:0] e);
    ent_t   r;
    longint s;
    s     = longint'($signed(v));
    r.eop = e;
    case (e)
      2'd0: begin
        r.imm = 16'(v);
        r.fit = (s >= -32768) && (s <= 32767);
      end
      2'd1: begin
        r.imm = 16'(v);
        r.fit = (v < 32'd65536);
      end
      2'd2: begin
        r.imm = 16'(v / 32'd65536);
        r.fit = (v % 32'd65536) == 0;
      end
      default: begin
        r.imm = 16'(v >> 2);
        r.fit = ((v % 32'd4) == 0) && (s >= -131072) && (s <= 131071);
      end
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last = '{imm: 16'h0, eop: 2'd0, fit: 1'b0};
    mcnt = 0;
  endtask

  // One clock: check all outputs at the negedge, then advance the model at the posedge.
  task automatic step();
    ent_t e;
    ent_t r;
    bit   acc;
    bit   pp;
    @(negedge clk);
    e = (q.size() > 0) ? q[0] : last;
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() > 0);
    chk("out_imm", out_imm, e.imm);
    chk("out_eop", out_eop, e.eop);
    chk("out_fit", out_fit, e.fit);
    chk("miss_cnt", miss_cnt, mcnt);
    if (out_valid && out_ready) dpops++;
    acc = in_valid && (q.size() < 2);
    pp  = (q.size() > 0) && out_ready;
    @(posedge clk);
    if (pp) last = q.pop_front();
    if (acc) begin
      r = ref_compress(in_val, in_eop);
      q.push_back(r);
      if (!r.fit && mcnt < (1 << CW) - 1) mcnt++;
    end
    if (clr_cnt) mcnt = 0;
    #1;
  endtask

  task automatic drive(input logic [31:0] v, input logic [1:0] e);
    in_valid = 1'b1;
    in_val   = v;
    in_eop   = e;
  endtask

  // Single value through an empty buffer with out_ready high; spot-check the result.
  task automatic one(input string tag, input logic [31:0] v, input logic [1:0] e,
                     input logic [15:0] ximm, input logic xfit);
    drive(v, e);
    step();
    in_valid = 1'b0;
    chk({tag, "_imm"}, out_imm, ximm);
    chk({tag, "_fit"}, out_fit, xfit);
    step();
  endtask

  initial begin
    logic [31:0] v;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_val    = '0;
    in_eop    = '0;
    out_ready = 1'b1;
    clr_cnt   = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    step();

    // Basic compressions, including unrepresentable ones.
    one("t1a", 32'hFFFF8000, 2'd0, 16'h8000, 1'b1);
    one("t1b", 32'h00008000, 2'd0, 16'h8000, 1'b0);
    chk("t1_miss", miss_cnt, 1);
    one("t2a", 32'h0000ABCD, 2'd1, 16'hABCD, 1'b1);
    one("t2b", 32'h12340000, 2'd2, 16'h1234, 1'b1);
    one("t2c", 32'hFFFFFFFC, 2'd3, 16'hFFFF, 1'b1);
    one("t2d", 32'h00000006, 2'd3, 16'h0001, 1'b0);

    // Backpressure: two entries fill the buffer, the third is held off.
    out_ready = 1'b0;
    drive(32'h0000_00A1, 2'd1); step();
    drive(32'h0000_00B2, 2'd1); step();
    drive(32'h0000_00C3, 2'd1);
    chk("t3_full", in_ready, 0);
    step(); step();
    out_ready = 1'b1;
    step(); step();
    in_valid = 1'b0;
    repeat (3) step();

    // Streaming: one entry per cycle with push and pop together.
    clr_cnt = 1'b1; step(); clr_cnt = 1'b0;
    dpops = 0;
    for (int i = 0; i < 8; i++) begin
      drive(32'(i), 2'd1);
      step();
    end
    in_valid = 1'b0;
    step(); step();
    chk("t4_pops", dpops, 8);
    chk("t4_miss", miss_cnt, 0);

    // Saturation of the 2-bit counter, then clear coinciding with a miss.
    for (int i = 0; i < 5; i++) begin
      drive(32'h0001_0000 + 32'(i), 2'd1);
      step();
    end
    in_valid = 1'b0;
    step();
    chk("t5_sat", miss_cnt, 3);
    drive(32'h0002_0000, 2'd1);
    clr_cnt = 1'b1;
    step();
    in_valid = 1'b0;
    clr_cnt  = 1'b0;
    chk("t5_clr", miss_cnt, 0);
    step();

    // Asynchronous reset in the middle of a cycle with a full buffer.
    out_ready = 1'b0;
    drive(32'h0003_0000, 2'd1); step();
    drive(32'h0004_0000, 2'd1); step();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t6_out_valid", out_valid, 0);
    chk("t6_in_ready", in_ready, 1);
    chk("t6_miss", miss_cnt, 0);
    chk("t6_out_imm", out_imm, 0);
    model_reset();
    reset     = 1'b0;
    out_ready = 1'b1;
    one("t6n", 32'h0000_1234, 2'd1, 16'h1234, 1'b1);
    chk("t6_alone", out_valid, 0);
    step();

    // Randomized traffic with values biased toward representable forms.
    for (int i = 0; i < 400; i++) begin
      v = $urandom;
      case ($urandom % 4)
        0: v = v;
        1: v = {{16{v[15]}}, v[15:0]};
        2: v = {v[31:16], 16'h0};
        default: v = {{14{v[17]}}, v[17:2], 2'b00};
      endcase
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      clr_cnt   = ($urandom % 20) == 0;
      in_val    = v;
      in_eop    = 2'($urandom);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    clr_cnt   = 1'b0;
    repeat (4) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
